// File: rtl/multi_debouncer.sv
// Multi-channel push-button/switch debouncer on the 1 kHz tick clock.
// Per channel: two-flop synchroniser, counter-based stability filter, edge pulses and typematic auto-repeat.
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_RATE   = 100,
    parameter int CNT_W         = 10
) (
    input  logic                clk_1KHz,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic [CHANNELS-1:0] press
);

    localparam int MAX_A     = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
    localparam int MAX_COUNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_C     = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C      = CNT_W'(REPEAT_RATE);

    generate
        if (MAX_COUNT > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
            $error("multi_debouncer: CNT_W=%0d cannot hold %0d", CNT_W, MAX_COUNT);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    always_ff @(posedge clk_1KHz or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= noisy;
            sync2 <= sync1;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             deb_q;
        logic             rise_q;
        logic             fall_q;
        logic             rpt_q;
        logic             press_q;
        logic             toggle;
        logic             rise_ev;
        logic             fall_ev;
        logic             rpt_w;

        // The filter only flips after the full run of disagreeing samples.
        assign toggle  = (sync2[ch] != deb_q) && (cnt == STABLE_LAST);
        assign rise_ev = toggle & ~deb_q;
        assign fall_ev = toggle & deb_q;

        always_ff @(posedge clk_1KHz or posedge reset) begin
            if (reset) begin
                cnt     <= '0;
                deb_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                rpt_q   <= 1'b0;
                press_q <= 1'b0;
            end else begin
                rise_q  <= rise_ev;
                fall_q  <= fall_ev;
                rpt_q   <= rpt_w;
                press_q <= rise_ev | rpt_w;
                if (sync2[ch] == deb_q) begin
                    cnt <= '0;
                end else if (toggle) begin
                    deb_q <= ~deb_q;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + ONE;
                end
            end
        end

        if (REPEAT_EN != 0) begin : g_rpt
            rpt_state_t       state;
            rpt_state_t       state_next;
            logic [CNT_W-1:0] rcnt;
            logic [CNT_W-1:0] rcnt_next;
            logic             rpt_next;

            always_ff @(posedge clk_1KHz or posedge reset) begin
                if (reset) begin
                    state <= IDLE;
                    rcnt  <= '0;
                end else begin
                    state <= state_next;
                    rcnt  <= rcnt_next;
                end
            end

            // A release takes priority, so no repeat can fire on the fall edge.
            always_comb begin
                state_next = state;
                rcnt_next  = rcnt;
                rpt_next   = 1'b0;
                if (rise_ev) begin
                    state_next = DELAY;
                    rcnt_next  = ONE;
                end else if (fall_ev) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else begin
                    case (state)
                        DELAY: begin
                            if (rcnt == DELAY_C) begin
                                rpt_next   = 1'b1;
                                rcnt_next  = ONE;
                                state_next = RPT;
                            end else begin
                                rcnt_next = rcnt + ONE;
                            end
                        end
                        RPT: begin
                            if (rcnt == RATE_C) begin
                                rpt_next  = 1'b1;
                                rcnt_next = ONE;
                            end else begin
                                rcnt_next = rcnt + ONE;
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            rcnt_next  = '0;
                        end
                    endcase
                end
            end

            assign rpt_w = rpt_next;
        end else begin : g_no_rpt
            assign rpt_w = 1'b0;
        end

        assign debounced[ch]    = deb_q;
        assign rise[ch]         = rise_q;
        assign fall[ch]         = fall_q;
        assign repeat_pulse[ch] = rpt_q;
        assign press[ch]        = press_q;
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer (2 channels, 4-sample filter, repeat 10/3).
module tb_multi_debouncer;

    logic       clk_1KHz;
    logic       reset;
    logic [1:0] noisy;
    logic [1:0] debounced;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] repeat_pulse;
    logic [1:0] press;

    int total;
    int bad;

    multi_debouncer #(
        .CHANNELS     (2),
        .STABLE_CYCLES(4),
        .REPEAT_EN    (1),
        .REPEAT_DELAY (10),
        .REPEAT_RATE  (3),
        .CNT_W        (10)
    ) dut (
        .clk_1KHz    (clk_1KHz),
        .reset       (reset),
        .noisy       (noisy),
        .debounced   (debounced),
        .rise        (rise),
        .fall        (fall),
        .repeat_pulse(repeat_pulse),
        .press       (press)
    );

    initial begin
        clk_1KHz = 1'b0;
        forever #5 clk_1KHz = ~clk_1KHz;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and land 1 time unit after it, away from the edge.
    task automatic tick();
        @(posedge clk_1KHz);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] val, input int edges);
        noisy = val;
        for (int i = 0; i < edges; i++) tick();
    endtask

    task automatic checkChannel(input int ch, input string phase, input int k,
                                input logic deb_e, input logic rise_e,
                                input logic fall_e, input logic rpt_e);
        checkOutput($sformatf("%s deb%0d@%0d", phase, ch, k), 32'(debounced[ch]), 32'(deb_e));
        checkOutput($sformatf("%s rise%0d@%0d", phase, ch, k), 32'(rise[ch]), 32'(rise_e));
        checkOutput($sformatf("%s fall%0d@%0d", phase, ch, k), 32'(fall[ch]), 32'(fall_e));
        checkOutput($sformatf("%s rpt%0d@%0d", phase, ch, k), 32'(repeat_pulse[ch]), 32'(rpt_e));
        checkOutput($sformatf("%s press%0d@%0d", phase, ch, k), 32'(press[ch]), 32'(rise_e | rpt_e));
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({debounced, rise, fall, repeat_pulse, press});
    endfunction

    initial begin
        logic [8:0] bounce;
        logic       rpt_e;
        logic       rpt1_e;
        total  = 0;
        bad    = 0;
        bounce = 9'b111101101;
        reset  = 1'b1;
        noisy  = 2'b00;

        // Reset, then 20 idle cycles with no activity on any output
        tick();
        tick();
        checkOutput("in_reset", allOutputs(), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checkOutput($sformatf("idle@%0d", k), allOutputs(), 32'h0);
        end

        // Three-sample glitch on channel 0 is rejected
        for (int k = 1; k <= 13; k++) begin
            noisy = (k <= 3) ? 2'b01 : 2'b00;
            tick();
            checkOutput($sformatf("glitch@%0d", k), allOutputs(), 32'h0);
        end

        // Press and hold ch0: rise at edge 6, repeats at 16,19,...; release before edge 38,
        // fall at 43 where a repeat would also be due
        for (int k = 1; k <= 50; k++) begin
            noisy = (k <= 37) ? 2'b01 : 2'b00;
            tick();
            rpt_e = (k >= 16) && (k < 43) && (((k - 16) % 3) == 0);
            checkChannel(0, "hold", k, (k >= 6) && (k < 43), k == 6, k == 43, rpt_e);
            checkOutput($sformatf("hold ch1@%0d", k),
                        32'({debounced[1], rise[1], fall[1], repeat_pulse[1], press[1]}), 32'h0);
        end

        // Bounce on ch1 while ch0 is steadily pressed; ch1 settles at edge 11
        for (int k = 1; k <= 40; k++) begin
            noisy[0] = 1'b1;
            noisy[1] = (k <= 9) ? bounce[k-1] : 1'b1;
            tick();
            rpt_e  = (k >= 16) && (((k - 16) % 3) == 0);
            rpt1_e = (k >= 21) && (((k - 21) % 3) == 0);
            checkChannel(0, "bounce", k, k >= 6, k == 6, 1'b0, rpt_e);
            checkChannel(1, "bounce", k, k >= 11, k == 11, 1'b0, rpt1_e);
        end

        // Release both, then press ch0 again and reset while it is in the delay phase
        applyStimulus(2'b00, 12);
        checkOutput("released", 32'(debounced), 32'h0);
        applyStimulus(2'b01, 8);
        checkOutput("pre_reset_deb", 32'(debounced), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", allOutputs(), 32'h0);
        tick();
        tick();
        checkOutput("held_reset", allOutputs(), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            rpt_e = (k >= 16) && (((k - 16) % 3) == 0);
            checkChannel(0, "post_reset", k, k >= 6, k == 6, 1'b0, rpt_e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
